// File: rtl/trace_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : trace_pkg                                                    |
// | Description : Record types and constants shared by the trace capture path. |
// |               Macro TRACE_TIMESTAMP_EN adds the 32-bit ts record field.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package trace_pkg;

    localparam int TRACE_DATA_W = 32;
    localparam int TRACE_ADDR_W = 9;
    localparam int TRACE_DROP_W = 16;

    typedef enum logic [1:0] {
        NONE   = 2'b00,
        MEM_RD = 2'b01,
        MEM_WR = 2'b10
    } mem_kind_t;

    typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
        logic [31:0]             ts;
`endif
        logic                    reg_v;
        logic [4:0]              reg_num;
        logic [TRACE_DATA_W-1:0] reg_data;
        mem_kind_t               mem_kind;
        logic [TRACE_ADDR_W-1:0] addr;
        logic [TRACE_DATA_W-1:0] mem_data;
    } trace_rec_t;

    // A store wins over a load when both strobes are high.
    function automatic mem_kind_t f_mem_kind(input logic i_wr, input logic i_rd);
        if (i_wr)
            return MEM_WR;
        else if (i_rd)
            return MEM_RD;
        else
            return NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : trace_fifo                                                   |
// | Description : Generic synchronous FIFO, wrap-bit pointers, registered level.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic [c_AW:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]) &&
                     (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);
    assign w_pop   = i_pop && !o_empty;
    // A simultaneous pop frees the slot the push lands in.
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = r_mem[r_rd_ptr[c_AW-1:0]];
    assign o_level = r_level;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/trace_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : trace_capture                                                |
// | Description : Packs core write-back / memory events into records, buffers  |
// |               them, drops new records when full. TRACE_TIMESTAMP_EN adds ts.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module trace_capture
    import trace_pkg::*;
#(
    parameter int DATA_W = TRACE_DATA_W,
    parameter int ADDR_W = TRACE_ADDR_W,
    parameter int DEPTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reg_write_sig,
    input  logic [4:0]              reg_num,
    input  logic [DATA_W-1:0]       reg_data,
    input  logic                    wr,
    input  logic                    rd,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [DATA_W-1:0]       rd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output trace_rec_t              out_rec,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic [TRACE_DROP_W-1:0] drop_cnt
);
    localparam int c_REC_W = $bits(trace_rec_t);

    mem_kind_t          w_kind;
    trace_rec_t         w_rec;
    logic               w_reg_evt;
    logic               w_rec_v;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [c_REC_W-1:0] w_fifo_q;
    logic               r_overflow;
    logic [TRACE_DROP_W-1:0] r_drop_cnt;

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] r_ts;

    always_ff @(posedge clk) begin
        if (reset)
            r_ts <= '0;
        else
            r_ts <= r_ts + 32'd1;
    end
`endif

    assign w_reg_evt = reg_write_sig && (reg_num != 5'd0);
    assign w_kind    = f_mem_kind(wr, rd);
    assign w_rec_v   = w_reg_evt || (w_kind != NONE);

    always_comb begin
        w_rec          = '0;
        w_rec.reg_v    = w_reg_evt;
        w_rec.mem_kind = w_kind;
        if (w_reg_evt) begin
            w_rec.reg_num  = reg_num;
            w_rec.reg_data = reg_data;
        end
        case (w_kind)
            MEM_WR: begin
                w_rec.addr     = addr;
                w_rec.mem_data = wr_data;
            end
            MEM_RD: begin
                w_rec.addr     = addr;
                w_rec.mem_data = rd_data;
            end
            default: ;
        endcase
`ifdef TRACE_TIMESTAMP_EN
        w_rec.ts = r_ts;
`endif
    end

    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;
    assign w_push    = w_rec_v && (!w_full || w_pop);
    assign w_drop    = w_rec_v && w_full && !w_pop;

    trace_fifo #(
        .WIDTH (c_REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (w_rec),
        .i_pop   (w_pop),
        .o_data  (w_fifo_q),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    // Storage is not reset, so mask the head while empty to present zeros.
    assign out_rec = out_valid ? trace_rec_t'(w_fifo_q) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != {TRACE_DROP_W{1'b1}})
                r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: doc/trace_capture.md
# trace_capture

Event-capture stage directly downstream of the `riscv` core. It samples the core's write-back outputs (`reg_write_sig`, `reg_num`, `reg_data`) and data-memory bus outputs (`wr`, `rd`, `addr`, `wr_data`, `rd_data`) every cycle. Each cycle carrying an architectural event is packed into one record and buffered in a FIFO. A testbench scoreboard or a debug UART drains the FIFO through a valid/ready port, and the core is never stalled.

## Interface

Parameters:
- `DATA_W`, default 32: register and memory data width.
- `ADDR_W`, default 9: memory address width.
- `DEPTH`, default 16: FIFO entries; must be a power of two and at least 2.

Ports (clock and reset first):
- `clk`, input, 1: the single clock.
- `reset`, input, 1: synchronous, active-high reset.
- `reg_write_sig`, input, 1: core register write strobe.
- `reg_num`, input, 5: destination register.
- `reg_data`, input, DATA_W: write-back value.
- `wr`, input, 1: memory write strobe.
- `rd`, input, 1: memory read strobe.
- `addr`, input, ADDR_W: memory address.
- `wr_data`, input, DATA_W: store data.
- `rd_data`, input, DATA_W: load data.
- `out_valid`, output, 1: head record present.
- `out_ready`, input, 1: consumer accepts the head record.
- `out_rec`, output, `trace_rec_t`: head record.
- `level`, output, $clog2(DEPTH)+1: current occupancy.
- `overflow`, output, 1: sticky flag; set when a record was dropped.
- `drop_cnt`, output, 16: count of dropped records; saturates at 16'hFFFF.

## Operation

Event qualification:
- `reg_evt` = `reg_write_sig` && `reg_num` != 0. Writes to x0 are filtered.
- `mem_kind` = MEM_WR if `wr`; else MEM_RD if `rd`; else NONE.
- If `wr` and `rd` are asserted together, the event is MEM_WR, and `rd_data` is ignored.
- A record is produced when `reg_evt` is set or `mem_kind` != NONE.

Record fields:
- `reg_v`, `reg_num`, `reg_data`: zeroed when `reg_evt` = 0.
- `mem_kind`, `addr`.
- `mem_data`: `wr_data` for MEM_WR, `rd_data` for MEM_RD, 0 for NONE.
- `addr` is zeroed when `mem_kind` = NONE.
- A register event and a memory event in the same cycle share one record.

FIFO behaviour:
- Push occurs when a record is produced and the FIFO is not full. Push and pop may happen in the same cycle.
- Drop policy when full: the new record is discarded and older records are preserved. If a pop is also happening in that cycle, the FIFO is not treated as full, and the push is accepted.
- On a drop, `overflow` is set and `drop_cnt` increments.
- `overflow` and `drop_cnt` clear only on `reset`.
- Pop occurs when `out_valid` && `out_ready`.
- Pointers are ADDR-wide plus one wrap bit. Full is when the indices are equal and the wrap bits differ. Empty is when the indices and wrap bits are both equal.

Reset values:
- `out_valid`=0, `level`=0, `overflow`=0, `drop_cnt`=0.
- `out_rec`=all zeros.
- Pointers are set to 0.
- Storage contents are not reset.
- Reset asserted mid-stream flushes all entries on the next edge. Events present in the reset cycle are not captured.

## Timing

- Capture latency: an event sampled at edge N is visible on `out_rec` with `out_valid`=1 after edge N, i.e. in cycle N+1. There is no same-cycle bypass from input to output.
- While `out_valid`=1 and `out_ready`=0, `out_rec` holds stable.
- `out_valid` does not depend combinationally on `out_ready`.
- `level` is registered and updates in the same cycle as the pointers.
- Back-to-back operation: one push and one pop per cycle, sustained indefinitely with no bubbles.

## Configuration

Macro `TRACE_TIMESTAMP_EN`:
- Defined: a 32-bit free-running cycle counter is added. It resets to 0 and wraps at 2^32. Its value at the capture edge is stored in the record field `ts`. Consecutive records therefore show cycle gaps.
- Undefined: the counter and the `ts` field are absent, and the record width shrinks by 32 bits.

## Structure

- Package `trace_pkg` holds:
  - `mem_kind_t` enum: NONE=2'b00, MEM_RD=2'b01, MEM_WR=2'b10.
  - `trace_rec_t` packed struct, including the `ts` field under the macro.
  - Constant `TRACE_DROP_W`=16.
- Sub-module `trace_fifo`: a generic synchronous FIFO parameterised on width and depth. It has push/pop, full/empty and level. Record packing and the drop logic stay in `trace_capture`.

## Test plan

- Reset, then `reg_write_sig`=1, `reg_num`=5, `reg_data`=32'h0000_00AA for one cycle -> next cycle `out_valid`=1, `reg_v`=1, `reg_num`=5, `reg_data`=AA, `mem_kind`=NONE, `level`=1.
- `reg_write_sig`=1, `reg_num`=0 -> no record is produced and `level` stays 0.
- One cycle with `rd`=1, `addr`=9'h040, `rd_data`=32'hDEAD_BEEF, plus a write to register 7 -> exactly one record with `reg_v`=1 and `mem_kind`=MEM_RD, `mem_data`=DEADBEEF.
- Hold `out_ready`=0 and inject 20 events with DEPTH=16 -> `level`=16, `overflow`=1, `drop_cnt`=4. The drained records are the first 16, in order.
- With the FIFO full, one cycle with `out_ready`=1 plus a new event -> push is accepted, `level` stays 16, and `drop_cnt` is unchanged.
- Assert `reset` while `level`=8 -> next cycle `level`=0, `out_valid`=0, `overflow`=0. With `TRACE_TIMESTAMP_EN` defined, an event 3 cycles after reset release shows `ts`=3.
